// File: rtl/mem_bank_pkg.sv
// rtl/mem_bank_pkg.sv - shared constants and FSM state encoding for memory_bank
package mem_bank_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - two-flop synchroniser with rising-edge pulse output
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  // Shift chain: s1/s2 resolve metastability, s3 holds the previous s2 for edge detect
  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser registers, cleared so an in-flight press is discarded on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/memory_bank.sv
// rtl/memory_bank.sv - small word memory with button store, clear sweep and registered read
module memory_bank
  import mem_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SYNC_STORE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  store,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] memory,
  output logic                  mem_valid,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   stored_count
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);

  logic store_pulse;

  generate
    if (SYNC_STORE != 0) begin : g_sync
      edge_sync u_store_sync (
        .clk   (clk),
        .reset (reset),
        .din   (store),
        .pulse (store_pulse)
      );
    end else begin : g_direct
      assign store_pulse = store;
    end
  endgenerate

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]        valid_q;

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    wr_valid;

  // FSM next state, single array write port (user write or sweep) and write-first read mux
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    wr_addr  = addr;
    wr_data  = data;
    wr_valid = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end else if (store_pulse) begin
          wr_en = 1'b1;
          if (!valid_q[addr] && (cnt_q < DEPTH_CNT)) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ST_CLEAR: begin
        wr_en    = 1'b1;
        wr_addr  = idx_q;
        wr_data  = '0;
        wr_valid = 1'b0;
        idx_d    = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_d  = wr_data;
      rd_valid_d = wr_valid;
    end else begin
      rd_data_d  = mem_q[rd_addr];
      rd_valid_d = valid_q[rd_addr];
    end
  end

  // Control and read registers; reset launches a fresh sweep from entry 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      idx_q      <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage array and valid bits are not reset; the clear sweep zeroes them
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_addr]   <= wr_data;
      valid_q[wr_addr] <= wr_valid;
    end
  end

  assign memory       = rd_data_q;
  assign mem_valid    = rd_valid_q;
  assign busy         = (state_q == ST_CLEAR);
  assign stored_count = cnt_q;

endmodule

// File: tb/tb_memory_bank.sv
// tb/tb_memory_bank.sv - self-checking bench for memory_bank in button and pulse store modes
module tb_memory_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] data;
  logic [1:0] addr;
  logic [1:0] rd_addr;
  logic       store_a;
  logic       store_b;

  logic [7:0] mem_a, mem_b;
  logic       val_a, val_b;
  logic       busy_a, busy_b;
  logic [2:0] cnt_a, cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] ref_mem [2][4];
  logic       ref_val [2][4];

  always #5 clk = ~clk;

  memory_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .SYNC_STORE(1)) u_btn (
    .clk(clk), .reset(reset), .data(data), .addr(addr), .store(store_a),
    .clear(clear), .rd_addr(rd_addr), .memory(mem_a), .mem_valid(val_a),
    .busy(busy_a), .stored_count(cnt_a)
  );

  memory_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .SYNC_STORE(0)) u_pls (
    .clk(clk), .reset(reset), .data(data), .addr(addr), .store(store_b),
    .clear(clear), .rd_addr(rd_addr), .memory(mem_b), .mem_valid(val_b),
    .busy(busy_b), .stored_count(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_valid(input int d);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(ref_val[d][i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) begin
        ref_mem[d][i] = 8'h00;
        ref_val[d][i] = 1'b0;
      end
  endtask

  task automatic model_write(input int d, input logic [1:0] a, input logic [7:0] v);
    ref_mem[d][a] = v;
    ref_val[d][a] = 1'b1;
  endtask

  task automatic check_sweep(input string tag);
    for (int c = 0; c < 4; c++) begin
      chk({tag, "_busy_a"}, busy_a, 1);
      chk({tag, "_busy_b"}, busy_b, 1);
      tick();
    end
    chk({tag, "_done_a"}, busy_a, 0);
    chk({tag, "_done_b"}, busy_b, 0);
    chk({tag, "_cnt_a"}, cnt_a, 0);
    chk({tag, "_cnt_b"}, cnt_b, 0);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      tick();
      chk({tag, "_mem_a"}, mem_a, ref_mem[0][a]);
      chk({tag, "_val_a"}, val_a, ref_val[0][a]);
      chk({tag, "_mem_b"}, mem_b, ref_mem[1][a]);
      chk({tag, "_val_b"}, val_b, ref_val[1][a]);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk({tag, "_rst_mem"}, mem_a, 0);
    chk({tag, "_rst_val"}, val_a, 0);
    chk({tag, "_rst_cnt"}, cnt_a, 0);
    model_clear();
    check_sweep(tag);
    read_all(tag);
  endtask

  // Button press: wrong data/addr on the first two edges, correct values only at the commit edge
  task automatic write_a(input logic [7:0] v, input logic [1:0] a);
    logic [7:0] old_m;
    logic       old_v;
    old_m   = ref_mem[0][a];
    old_v   = ref_val[0][a];
    rd_addr = a;
    data    = ~v;
    addr    = a + 2'd1;
    store_a = 1'b1;
    tick();
    chk("btn_e0_mem", mem_a, old_m);
    tick();
    chk("btn_e1_mem", mem_a, old_m);
    chk("btn_e1_val", val_a, old_v);
    data = v;
    addr = a;
    tick();
    model_write(0, a, v);
    chk("btn_e2_mem", mem_a, v);
    chk("btn_e2_val", val_a, 1);
    data = $urandom;
    for (int i = 0; i < 7; i++) tick();
    store_a = 1'b0;
    tick();
    tick();
    chk("btn_hold_mem", mem_a, v);
    chk("btn_cnt", cnt_a, count_valid(0));
  endtask

  task automatic write_b(input logic [7:0] v, input logic [1:0] a);
    rd_addr = a;
    data    = v;
    addr    = a;
    store_b = 1'b1;
    tick();
    store_b = 1'b0;
    model_write(1, a, v);
    chk("pls_wf_mem", mem_b, v);
    chk("pls_wf_val", val_b, 1);
    chk("pls_cnt", cnt_b, count_valid(1));
  endtask

  initial begin
    logic [7:0] v;
    logic [1:0] a;
    logic [1:0] r;
    logic       s;

    reset   = 1'b1;
    clear   = 1'b0;
    data    = 8'h00;
    addr    = 2'd0;
    rd_addr = 2'd0;
    store_a = 1'b0;
    store_b = 1'b0;
    tick();
    tick();

    do_reset("por");

    write_a(8'hA5, 2'd2);
    chk("btn_one_write_cnt", cnt_a, 1);
    read_all("btn");

    write_a(8'h11, 2'd0);
    write_a(8'h22, 2'd1);
    write_a(8'h33, 2'd2);
    write_a(8'h44, 2'd3);
    chk("fill_cnt", cnt_a, 4);
    write_a(8'h55, 2'd1);
    chk("overwrite_cnt", cnt_a, 4);
    read_all("fill");

    write_b(8'h7E, 2'd3);

    for (int i = 0; i < 24; i++) begin
      v = 8'($urandom);
      a = 2'($urandom_range(0, 3));
      r = 2'($urandom_range(0, 3));
      s = 1'($urandom_range(0, 1));
      rd_addr = r;
      data    = v;
      addr    = a;
      store_b = s;
      tick();
      store_b = 1'b0;
      if (s) model_write(1, a, v);
      chk("rand_mem", mem_b, ref_mem[1][r]);
      chk("rand_val", val_b, ref_val[1][r]);
      chk("rand_cnt", cnt_b, count_valid(1));
    end
    chk("rand_cnt_max", cnt_b <= 3'd4, 1);

    clear   = 1'b1;
    store_b = 1'b1;
    addr    = 2'd0;
    data    = 8'hEE;
    tick();
    chk("clr_c1_busy_a", busy_a, 1);
    chk("clr_c1_busy_b", busy_b, 1);
    store_b = 1'b0;
    tick();
    chk("clr_c2_busy_b", busy_b, 1);
    store_b = 1'b1;
    tick();
    store_b = 1'b0;
    chk("clr_c3_busy_b", busy_b, 1);
    tick();
    chk("clr_c4_busy_a", busy_a, 1);
    chk("clr_c4_busy_b", busy_b, 1);
    clear = 1'b0;
    tick();
    chk("clr_end_busy_a", busy_a, 0);
    chk("clr_end_busy_b", busy_b, 0);
    chk("clr_cnt_a", cnt_a, 0);
    chk("clr_cnt_b", cnt_b, 0);
    model_clear();
    read_all("clr");

    write_b(8'h99, 2'd0);
    write_a(8'h66, 2'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("mid_c1_busy", busy_a, 1);
    tick();
    chk("mid_c2_busy", busy_a, 1);
    do_reset("mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
